spi_sclk_engine: RTL and testbench
==================================

// Module: spi_sclk_engine
// PURPOSE
//  Parametrised successor of the SPI clock generator. Generates a burst of bit_count SCLK cycles on request,
//  in any of the 4 SPI modes (CPOL/CPHA), with a programmable divider from wb_clk.
//  Emits single-cycle launch/sample strobes aligned to SCLK edges for the shift register, plus busy/done
//  handshake for the SPI master control FSM. Sits between the Wishbone register file and the shifter.
// PARAMETERS
//  DIV_WIDTH   16  width of divider; SCLK half-period = divider+1 wb_clk cycles
//  CNT_WIDTH   6   width of bit_count; max burst = 2**CNT_WIDTH-1 bits
// PORTS
//  wb_clk      in   1          system clock; all logic on rising edge
//  reset       in   1          synchronous, active-high reset
//  divider     in   DIV_WIDTH  half-period minus one; latched on accepted go
//  cpol        in   1          idle SCLK level; latched on accepted go (tracked live while idle)
//  cpha        in   1          0: sample leading/launch trailing; 1: launch leading/sample trailing; latched on go
//  bit_count   in   CNT_WIDTH  bits in burst; latched on accepted go; 0 = go ignored
//  go          in   1          start request, accepted only in IDLE
//  sclk        out  1          SPI serial clock (registered)
//  busy        out  1          high from cycle after accepted go until done cycle (exclusive)
//  done        out  1          1-cycle pulse at burst end
//  launch_stb  out  1          1-cycle: shifter drives next MOSI bit
//  sample_stb  out  1          1-cycle: shifter captures MISO
// BEHAVIOUR
//  - Reset: state=IDLE, sclk=0, busy=0, done=0, launch_stb=0, sample_stb=0, counters=0; overrides any burst mid-operation, no done.
//  - All outputs registered. States: IDLE, RUN, TAIL.
//  - IDLE: sclk<=cpol each cycle. go && bit_count!=0 at edge T: latch inputs, hcnt<=divider, ecnt<=2*bit_count
//    (CNT_WIDTH+1 bits), ->RUN; busy=1 from T. cpha=0: launch_stb=1 in cycle after T (first data bit).
//  - RUN: each cycle if hcnt!=0 hcnt--; else toggle sclk, hcnt<=divider, ecnt--. Edge k (1..2N):
//    odd=leading, even=trailing. cpha=0: sample_stb on leading, launch_stb on trailing except edge 2N.
//    cpha=1: launch_stb on leading, sample_stb on trailing. Strobes coincide with the sclk toggle cycle.
//  - First edge at T+1+divider; edges spaced divider+1; last edge (ecnt->0) at T+2N(divider+1); ->TAIL, hcnt<=divider.
//  - TAIL: sclk holds latched cpol for divider+1 cycles, then done=1, busy=0 same cycle, ->IDLE.
//  - Total busy cycles = (2N+1)(divider+1). done is high exactly one cycle.
//  - go while busy or in done cycle: ignored (no queueing). Input changes during burst: no effect.
//  - divider=0: sclk = wb_clk/2, strobes every cycle. divider all-ones: no overflow, hcnt same width.
//  - bit_count=0 with go: no state change, busy/done stay 0.
//  - launch_stb and sample_stb never high in the same cycle.
// CONFIGURATION
//  - SPI_CLKGEN_LEGACY_EN defined: extra outputs cpol0, cpol1 (1 bit each). cpol0 = free-running clock,
//    toggles every divider+1 cycles (live divider, own counter) regardless of go/busy; reset 0; cpol1 = ~cpol0.
//  - Not defined: ports and counter absent; no free-running activity.
// TESTING
//  - reset pulse mid-burst (divider=3,N=8,edge 5) -> next cycle sclk=0,busy=0, no done; then sclk=cpol.
//  - divider=1,N=8,cpol=0,cpha=0, go at T -> busy from T, 16 sclk edges first at T+2 spacing 2, done at T+34; 8 sample, 8 launch.
//  - divider=0,N=1,cpol=1,cpha=1 -> sclk 1,0,1, launch at edge1, sample at edge2, done T+3, sclk idles 1.
//  - go held high continuously, divider=2,N=4 -> back-to-back bursts, new busy one cycle after done, no overlap.
//  - bit_count=0 with go -> busy/done/sclk unchanged; go mid-burst -> ignored, done count unchanged.
//  - SPI_CLKGEN_LEGACY_EN, divider=2 -> cpol0 period 6 cycles from reset, cpol1 inverse, unaffected by go.

Source files
------------

// File: rtl/spi_sclk_engine.sv
// SPI serial clock engine: bursts of bit_count SCLK cycles in any CPOL/CPHA
// mode, with launch/sample strobes for the shifter and a busy/done handshake.
//
// Parameters: DIV_WIDTH (divider width), CNT_WIDTH (bit_count width).
// Ports:
//   wb_clk, reset           system clock, synchronous active-high reset
//   divider                 SCLK half-period minus one (wb_clk cycles)
//   cpol, cpha              SPI mode, latched when go is accepted
//   bit_count               bits per burst, 0 makes go a no-op
//   go                      start request, honoured only when idle
//   sclk                    registered SPI clock
//   busy, done              burst in progress / one-cycle end pulse
//   launch_stb, sample_stb  one-cycle shifter strobes on SCLK edges
// Optional build macro SPI_CLKGEN_LEGACY_EN adds cpol0/cpol1, a free-running
// clock pair toggling every divider+1 cycles from the live divider.
module spi_sclk_engine #(
    parameter int DIV_WIDTH = 16,
    parameter int CNT_WIDTH = 6
) (
    input  logic                 wb_clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic [CNT_WIDTH-1:0] bit_count,
    input  logic                 go,
    output logic                 sclk,
    output logic                 busy,
    output logic                 done,
    output logic                 launch_stb,
    output logic                 sample_stb
`ifdef SPI_CLKGEN_LEGACY_EN
    ,
    output logic                 cpol0,
    output logic                 cpol1
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        TAIL
    } state_t;

    localparam logic [DIV_WIDTH-1:0] HONE = 1;
    localparam logic [CNT_WIDTH:0]   EONE = 1;

    state_t               state;
    logic [DIV_WIDTH-1:0] hcnt;
    logic [DIV_WIDTH-1:0] div_q;
    logic [CNT_WIDTH:0]   ecnt;
    logic                 cpol_q;
    logic                 cpha_q;
    logic                 leading;
    logic                 last;

    // ecnt counts remaining edges; an even remainder means the next
    // edge has an odd index, i.e. it is the leading edge of a bit.
    assign leading = ~ecnt[0];
    assign last    = (ecnt == EONE);

    always_ff @(posedge wb_clk) begin
        if (reset) begin
            state      <= IDLE;
            hcnt       <= '0;
            div_q      <= '0;
            ecnt       <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            sclk       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            launch_stb <= 1'b0;
            sample_stb <= 1'b0;
        end else begin
            done       <= 1'b0;
            launch_stb <= 1'b0;
            sample_stb <= 1'b0;
            case (state)
                IDLE: begin
                    sclk <= cpol;
                    if (go && (bit_count != '0)) begin
                        div_q      <= divider;
                        cpol_q     <= cpol;
                        cpha_q     <= cpha;
                        hcnt       <= divider;
                        ecnt       <= {bit_count, 1'b0};
                        busy       <= 1'b1;
                        // CPHA=0 drives the first bit before any edge
                        launch_stb <= ~cpha;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (hcnt != '0) begin
                        hcnt <= hcnt - HONE;
                    end else begin
                        sclk <= ~sclk;
                        hcnt <= div_q;
                        ecnt <= ecnt - EONE;
                        if (cpha_q) begin
                            launch_stb <= leading;
                            sample_stb <= ~leading;
                        end else begin
                            sample_stb <= leading;
                            // no bit follows the final trailing edge
                            launch_stb <= ~leading & ~last;
                        end
                        if (last) begin
                            state <= TAIL;
                        end
                    end
                end
                TAIL: begin
                    if (hcnt != '0) begin
                        hcnt <= hcnt - HONE;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_CLKGEN_LEGACY_EN
    logic [DIV_WIDTH-1:0] lcnt;

    // >= keeps the counter bounded if the live divider shrinks
    always_ff @(posedge wb_clk) begin
        if (reset) begin
            lcnt  <= '0;
            cpol0 <= 1'b0;
            cpol1 <= 1'b1;
        end else if (lcnt >= divider) begin
            lcnt  <= '0;
            cpol0 <= ~cpol0;
            cpol1 <= ~cpol1;
        end else begin
            lcnt <= lcnt + HONE;
        end
    end
`endif

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Self-checking bench for spi_sclk_engine: directed scenarios then random
// bursts, compared cycle by cycle with a timeline model of each burst.
module tb_spi_sclk_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] divider;
    logic        cpol;
    logic        cpha;
    logic [5:0]  bit_count;
    logic        go;
    logic        sclk;
    logic        busy;
    logic        done;
    logic        launch_stb;
    logic        sample_stb;
`ifdef SPI_CLKGEN_LEGACY_EN
    logic        cpol0;
    logic        cpol1;
`endif

    always #5 clk = ~clk;

    spi_sclk_engine dut (
        .wb_clk     (clk),
        .reset      (reset),
        .divider    (divider),
        .cpol       (cpol),
        .cpha       (cpha),
        .bit_count  (bit_count),
        .go         (go),
        .sclk       (sclk),
        .busy       (busy),
        .done       (done),
        .launch_stb (launch_stb),
        .sample_stb (sample_stb)
`ifdef SPI_CLKGEN_LEGACY_EN
        ,
        .cpol0      (cpol0),
        .cpol1      (cpol1)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // burst timeline model
    bit m_act  = 0;
    int m_t0   = 0;
    int m_d    = 0;
    int m_n    = 0;
    bit m_cpol = 0;
    bit m_cpha = 0;

    logic e_sclk, e_busy, e_done, e_launch, e_sample;

    int cnt_launch = 0;
    int cnt_sample = 0;
    int cnt_done   = 0;
    int cnt_edges  = 0;
    logic prev_sclk = 1'b0;

    bit leg_on = 0;
    int leg_k  = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected outputs after this edge, from the burst timeline:
    // edge k of 2N lands k*(d+1) cycles after acceptance, and the
    // burst ends (2N+1)*(d+1) cycles after acceptance.
    task automatic model();
        int t, p, total, k;
        e_sclk = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        e_launch = 1'b0; e_sample = 1'b0;
        if (reset) begin
            m_act = 0;
        end else if (!m_act) begin
            e_sclk = cpol;
            if (go && bit_count != 0) begin
                m_act = 1; m_t0 = cyc;
                m_d = int'(divider); m_n = int'(bit_count);
                m_cpol = cpol; m_cpha = cpha;
                e_busy = 1'b1;
                e_launch = !cpha;
            end
        end else begin
            t = cyc - m_t0;
            p = m_d + 1;
            total = (2 * m_n + 1) * p;
            if (t == total) begin
                e_done = 1'b1;
                e_sclk = m_cpol;
                m_act = 0;
            end else begin
                e_busy = 1'b1;
                k = t / p;
                if (k > 2 * m_n) k = 2 * m_n;
                e_sclk = m_cpol ^ k[0];
                if (t % p == 0) begin
                    if (m_cpha) begin
                        e_launch = k[0];
                        e_sample = !k[0];
                    end else begin
                        e_sample = k[0];
                        e_launch = !k[0] && (k != 2 * m_n);
                    end
                end
            end
        end
        if (reset) leg_k = 0;
        else leg_k++;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            model();
            #1;
            chk("sclk", sclk, e_sclk);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("launch_stb", launch_stb, e_launch);
            chk("sample_stb", sample_stb, e_sample);
            chk("strobe_excl", launch_stb & sample_stb, 1'b0);
`ifdef SPI_CLKGEN_LEGACY_EN
            if (leg_on) begin
                chk("cpol0", cpol0, 1'(((leg_k / 3) % 2) != 0));
                chk("cpol1", cpol1, 1'(((leg_k / 3) % 2) == 0));
            end
`endif
            cnt_launch += int'(launch_stb);
            cnt_sample += int'(sample_stb);
            cnt_done   += int'(done);
            if (sclk !== prev_sclk) cnt_edges++;
            prev_sclk = sclk;
        end
    endtask

    task automatic clr_counts();
        cnt_launch = 0; cnt_sample = 0; cnt_done = 0; cnt_edges = 0;
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; divider = 16'd0;
        cpol = 1'b0; cpha = 1'b0; bit_count = 6'd0;
        tick(2);
        reset = 1'b0;
        tick(3);

        // reset lands on the fifth edge of a burst
        divider = 16'd3; bit_count = 6'd8; cpol = 1'b0; cpha = 1'b0;
        go = 1'b1; tick(1); go = 1'b0;
        tick(19);
        clr_counts();
        reset = 1'b1; tick(1); reset = 1'b0;
        cpol = 1'b1;
        tick(6);
        chk_int("rst_no_done", cnt_done, 0);

        // divider=1, N=8, mode 0
        divider = 16'd1; bit_count = 6'd8; cpol = 1'b0; cpha = 1'b0;
        tick(2);
        clr_counts();
        go = 1'b1; tick(1); go = 1'b0;
        tick(36);
        chk_int("m0_edges", cnt_edges, 16);
        chk_int("m0_samples", cnt_sample, 8);
        chk_int("m0_launches", cnt_launch, 8);
        chk_int("m0_done", cnt_done, 1);

        // divider=0, N=1, mode 3
        divider = 16'd0; bit_count = 6'd1; cpol = 1'b1; cpha = 1'b1;
        tick(2);
        clr_counts();
        go = 1'b1; tick(1); go = 1'b0;
        tick(5);
        chk_int("m3_launches", cnt_launch, 1);
        chk_int("m3_samples", cnt_sample, 1);
        chk_int("m3_done", cnt_done, 1);

        // go held high: back-to-back bursts
        divider = 16'd2; bit_count = 6'd4; cpol = 1'b0; cpha = 1'b1;
        clr_counts();
        go = 1'b1; tick(27 * 3 + 2); go = 1'b0;
        tick(30);
        chk_int("b2b_done", cnt_done, 3);

        // bit_count=0 is a no-op; go and input changes mid-burst ignored
        bit_count = 6'd0; go = 1'b1; tick(4); go = 1'b0;
        divider = 16'd1; bit_count = 6'd3; cpol = 1'b1; cpha = 1'b0;
        clr_counts();
        go = 1'b1; tick(1); go = 1'b0;
        tick(4);
        divider = 16'd5; cpol = 1'b0; cpha = 1'b1; bit_count = 6'd9;
        go = 1'b1; tick(3); go = 1'b0;
        bit_count = 6'd0;
        tick(12);
        chk_int("midgo_done", cnt_done, 1);

        // random bursts with occasional resets
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            go        = ($urandom_range(0, 3) == 0);
            divider   = 16'($urandom_range(0, 3));
            bit_count = 6'($urandom_range(0, 5));
            cpol      = 1'($urandom);
            cpha      = 1'($urandom);
            tick(1);
        end
        reset = 1'b0; go = 1'b0;
        tick(80);

`ifdef SPI_CLKGEN_LEGACY_EN
        divider = 16'd2;
        reset = 1'b1; tick(1); reset = 1'b0;
        leg_on = 1;
        for (int i = 0; i < 60; i++) begin
            go        = 1'($urandom);
            bit_count = 6'($urandom_range(0, 3));
            tick(1);
        end
        leg_on = 0;
        go = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
